// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute handshake bundle for the immediate generator.
// The generator itself takes the slave modport; the producer/consumer side takes master.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: combinational decode, registered into a two-entry
// skid buffer (main drives outputs, skid absorbs one stall), plus illegal-opcode counter.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  imm_gen_pipe_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ill_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    F_I, F_S, F_B, F_U, F_J, F_SHAMT, F_ZIMM, F_NONE
  } fmt_e;

  typedef logic signed [XLEN-1:0] simm_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  localparam entry_t RST_E = '{inst: '0, imm: '0, fmt: F_NONE, illegal: 1'b0};

  // Every format fits a 32-bit signed value; widening to XLEN is a plain sign extension.
  function automatic entry_t decode(input logic [31:0] ins);
    entry_t            e;
    logic signed [31:0] v;
    e.inst    = ins;
    e.fmt     = F_I;
    e.illegal = 1'b0;
    v         = {{20{ins[31]}}, ins[31:20]};
    case (ins[6:0])
      7'b0010011: begin
        if (ins[13:12] == 2'b01) begin
          e.fmt = F_SHAMT;
          v     = {26'b0, (XLEN == 64) ? ins[25] : 1'b0, ins[24:20]};
        end
      end
      7'b0000011, 7'b1100111: ;
      7'b0100011: begin
        e.fmt = F_S;
        v     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        e.fmt = F_B;
        v     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = F_U;
        v     = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        e.fmt = F_J;
        v     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1110011: begin
        e.fmt = ins[14] ? F_ZIMM : F_NONE;
        v     = ins[14] ? {27'b0, ins[19:15]} : '0;
      end
      7'b0110011: begin
        e.fmt = F_NONE;
        v     = '0;
      end
      default: e.illegal = 1'b1;
    endcase
    e.imm = simm_t'(v);
    return e;
  endfunction

  entry_t           main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           dec;
  logic             accept, pop;

  assign dec    = decode(bus.in_inst);
  assign accept = bus.in_valid & rdy_q;
  assign pop    = main_vld_q & bus.out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    // A full skid means in_ready was low, so a pop here never coincides with an accept.
    if (pop && skid_vld_q) begin
      main_d     = skid_q;
      skid_vld_d = 1'b0;
    end else if (accept && (!main_vld_q || pop)) begin
      main_d     = dec;
      main_vld_d = 1'b1;
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end else if (pop) begin
      main_vld_d = 1'b0;
    end
    rdy_d = ~skid_vld_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && dec.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= RST_E;
      skid_q     <= RST_E;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = main_vld_q;
  assign bus.out_inst    = main_q.inst;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
  assign ill_cnt         = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN32, XLEN64, CNT_W=2) fed identical stimulus,
// checked against a two-deep FIFO reference model and an arithmetic immediate model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;
  logic [15:0] cnt64;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) i32 ();
  imm_gen_pipe_if #(.XLEN(64)) i64 ();
  imm_gen_pipe_if #(.XLEN(32)) ic2 ();

  assign i32.in_valid = in_valid;  assign i32.in_inst = in_inst;  assign i32.out_ready = out_ready;
  assign i64.in_valid = in_valid;  assign i64.in_inst = in_inst;  assign i64.out_ready = out_ready;
  assign ic2.in_valid = in_valid;  assign ic2.in_inst = in_inst;  assign ic2.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .bus(i32), .cnt_clr(cnt_clr), .ill_cnt(cnt16));
  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .bus(i64), .cnt_clr(cnt_clr), .ill_cnt(cnt64));
  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dutc2 (
    .clk(clk), .rst(rst), .bus(ic2), .cnt_clr(cnt_clr), .ill_cnt(cnt2));

  int n_tot  = 0;
  int n_pass = 0;

  logic [31:0] q[$];
  int          m_cnt16 = 0;
  int          m_cnt2  = 0;
  bit          rdy_ok  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit ref_ill(input logic [31:0] ins);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h13:        return (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 5 : 0;
      7'h23:        return 1;
      7'h63:        return 2;
      7'h37, 7'h17: return 3;
      7'h6F:        return 4;
      7'h73:        return ins[14] ? 6 : 7;
      7'h33:        return 7;
      default:      return 0;
    endcase
  endfunction

  // Offsets as signed integers, then truncated to the requested XLEN.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xl);
    longint v;
    case (ref_fmt(ins))
      0: v = $signed(ins[31:20]);
      1: v = $signed({ins[31:25], ins[11:7]});
      2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3: v = $signed({ins[31:12], 12'h000});
      4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      5: v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    return (xl == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  task automatic step();
    bit acc, pp;
    @(negedge clk);
    chk("in_ready", 64'(i32.in_ready), 64'(rdy_ok && q.size() < 2));
    chk("out_valid", 64'(i32.out_valid), 64'(q.size() > 0));
    chk("out_valid64", 64'(i64.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_inst", 64'(i32.out_inst), 64'(q[0]));
      chk("out_imm32", 64'(i32.out_imm), ref_imm(q[0], 32));
      chk("out_imm64", i64.out_imm, ref_imm(q[0], 64));
      chk("out_fmt", 64'(i32.out_fmt), 64'(ref_fmt(q[0])));
      chk("out_fmt64", 64'(i64.out_fmt), 64'(ref_fmt(q[0])));
      chk("out_illegal", 64'(i32.out_illegal), 64'(ref_ill(q[0])));
      chk("out_inst_c2", 64'(ic2.out_inst), 64'(q[0]));
    end
    acc = in_valid && rdy_ok && (q.size() < 2);
    pp  = out_ready && (q.size() > 0);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(in_inst);
    if (cnt_clr) begin
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else if (acc && ref_ill(in_inst)) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    rdy_ok = 1'b1;
    #1;
    chk("ill_cnt16", 64'(cnt16), 64'(m_cnt16));
    chk("ill_cnt64", 64'(cnt64), 64'(m_cnt16));
    chk("ill_cnt2", 64'(cnt2), 64'(m_cnt2));
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 64'(i32.out_valid), 64'd0);
    chk("rst_out_valid64", 64'(i64.out_valid), 64'd0);
    chk("rst_in_ready", 64'(i32.in_ready), 64'd0);
    chk("rst_out_inst", 64'(i32.out_inst), 64'd0);
    chk("rst_out_imm64", i64.out_imm, 64'd0);
    chk("rst_out_fmt", 64'(i32.out_fmt), 64'd7);
    chk("rst_out_illegal", 64'(i32.out_illegal), 64'd0);
    chk("rst_ill_cnt", 64'(cnt16), 64'd0);
  endtask

  task automatic push_expect(input logic [31:0] ins, input logic [63:0] e64, input int ef);
    in_valid = 1'b1;
    in_inst  = ins;
    step();
    in_valid = 1'b0;
    chk("dir_imm64", i64.out_imm, e64);
    chk("dir_imm32", 64'(i32.out_imm), {32'h0, e64[31:0]});
    chk("dir_fmt", 64'(i64.out_fmt), 64'(ef));
  endtask

  initial begin
    logic [6:0] ops [12];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F, 7'h0B};

    // Reset held across a clock edge
    @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    rdy_ok = 1'b0;
    q.delete();
    out_ready = 1'b1;
    step();

    // Directed immediates with fixed expected values
    push_expect(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    push_expect(32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    push_expect(32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 4);
    push_expect(32'h4030D093, 64'h0000_0000_0000_0003, 5);
    push_expect(32'h3002D073, 64'h0000_0000_0000_0005, 6);
    push_expect(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3);
    push_expect(32'h00208033, 64'h0, 7);
    step();

    // Three illegal opcodes back to back
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_inst = 32'h1234_5000 | 32'(i << 12) | 32'h7F;
      step();
    end
    in_valid = 1'b0;
    chk("ill_cnt_three", 64'(cnt16), 64'd3);
    // Clear coinciding with an illegal accept
    in_valid = 1'b1;
    in_inst  = 32'h0000_007F;
    cnt_clr  = 1'b1;
    step();
    cnt_clr  = 1'b0;
    chk("ill_cnt_clr_wins", 64'(cnt16), 64'd0);
    for (int i = 0; i < 5; i++) begin
      in_inst = 32'hABCD_E07F;
      step();
    end
    in_valid = 1'b0;
    chk("ill_cnt_sat2", 64'(cnt2), 64'd3);
    chk("ill_cnt_five", 64'(cnt16), 64'd5);
    step();
    step();

    // Stall: A,B accepted, C refused until the cycle after the first pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h0010_0093;  step();
    in_inst   = 32'h0020_0113;  step();
    in_inst   = 32'h0030_0193;  step();
    step();
    chk("stall_in_ready", 64'(i32.in_ready), 64'd0);
    chk("stall_head", 64'(i32.out_inst), 64'h0010_0093);
    out_ready = 1'b1;
    step();
    chk("release_in_ready", 64'(i32.in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("drained", 64'(q.size()), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      in_inst   = {$urandom()} & 32'hFFFF_FF80;
      in_inst[6:0] = ops[$urandom_range(0, 11)];
      step();
    end
    cnt_clr = 1'b0;

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h0050_0293;  step();
    in_inst   = 32'h0060_0313;  step();
    in_valid  = 1'b0;
    step();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_state();
    q.delete();
    m_cnt16 = 0;
    m_cnt2  = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_ok = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid  = ($urandom_range(0, 1) != 0);
      in_inst   = {$urandom()} & 32'hFFFF_FF80;
      in_inst[6:0] = ops[$urandom_range(0, 11)];
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
